// File: rtl/rc5_pkg.sv
// Shared constants, state encoding and rotate helpers for the RC5-16/12/16 cipher core.
// RC5_DECRYPT_EN adds the FINAL state used by the decrypt path.
package rc5_pkg;

    localparam int unsigned W   = 16;
    localparam int unsigned R   = 12;
    localparam int unsigned T   = 2 * (R + 1);
    localparam int unsigned LGW = 4;

    typedef logic [W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
`ifdef RC5_DECRYPT_EN
        FINAL = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    // Shifting a doubled word keeps the rotate free of variable-width arithmetic.
    function automatic word_t rotl(input word_t x, input logic [LGW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    function automatic word_t rotr(input word_t x, input logic [LGW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} >> n;
        return t[W-1:0];
    endfunction

endpackage

// File: rtl/rc5_round.sv
// One combinational RC5 round; encrypt always, decrypt added under RC5_DECRYPT_EN.
module rc5_round
    import rc5_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] s_even,
    input  logic [W-1:0] s_odd,
`ifdef RC5_DECRYPT_EN
    input  logic         dec,
`endif
    output logic [W-1:0] a_next,
    output logic [W-1:0] b_next
);

    word_t enc_a;
    word_t enc_b;

    always_comb begin
        enc_a = rotl(a ^ b, b[LGW-1:0]) + s_even;
        enc_b = rotl(b ^ enc_a, enc_a[LGW-1:0]) + s_odd;
    end

`ifdef RC5_DECRYPT_EN
    word_t dec_a;
    word_t dec_b;

    // Decrypt undoes B first, then A using the freshly recovered B.
    always_comb begin
        dec_b  = rotr(b - s_odd, a[LGW-1:0]) ^ a;
        dec_a  = rotr(a - s_even, dec_b[LGW-1:0]) ^ dec_b;
        a_next = dec ? dec_a : enc_a;
        b_next = dec ? dec_b : enc_b;
    end
`else
    assign a_next = enc_a;
    assign b_next = enc_b;
`endif

endmodule

// File: rtl/rc5_cipher.sv
// Iterative RC5-16/12/16 core: one round per clock, valid/ready on input and output.
// Define RC5_DECRYPT_EN to honour mode_dec and build the decrypt path.
module rc5_cipher
    import rc5_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [T-1:0][W-1:0] sub,
    input  logic                keys_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*W-1:0]      in_data,
    input  logic                mode_dec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*W-1:0]      out_data
);

    localparam logic [3:0] I_LAST = 4'(R);

    state_t     state;
    state_t     state_next;
    logic [3:0] i;
    logic [3:0] i_next;
    word_t      a;
    word_t      b;
    word_t      a_next;
    word_t      b_next;
    word_t      ra;
    word_t      rb;
    logic       armed;

`ifdef RC5_DECRYPT_EN
    logic dec;
    logic dec_next;
`else
    logic unused_mode;
    assign unused_mode = mode_dec;
`endif

    rc5_round u_round (
        .a      (a),
        .b      (b),
        .s_even (sub[{i, 1'b0}]),
        .s_odd  (sub[{i, 1'b1}]),
`ifdef RC5_DECRYPT_EN
        .dec    (dec),
`endif
        .a_next (ra),
        .b_next (rb)
    );

    assign out_data = {b, a};

    always_comb begin
        state_next = state;
        a_next     = a;
        b_next     = b;
        i_next     = i;
        // armed is low for the first cycle out of reset so in_ready starts at 0.
        in_ready   = armed && keys_ready && (state == IDLE);
        out_valid  = 1'b0;
`ifdef RC5_DECRYPT_EN
        dec_next   = dec;
`endif
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_next = ROUND;
`ifdef RC5_DECRYPT_EN
                    dec_next = mode_dec;
                    if (mode_dec) begin
                        a_next = in_data[W-1:0];
                        b_next = in_data[2*W-1:W];
                        i_next = I_LAST;
                    end else
`endif
                    begin
                        a_next = in_data[W-1:0] + sub[0];
                        b_next = in_data[2*W-1:W] + sub[1];
                        i_next = 4'd1;
                    end
                end
            end
            ROUND: begin
                if (!keys_ready) begin
                    state_next = IDLE;
                    i_next     = '0;
                end else begin
                    a_next = ra;
                    b_next = rb;
`ifdef RC5_DECRYPT_EN
                    if (dec) begin
                        i_next = i - 4'd1;
                        if (i == 4'd1) state_next = FINAL;
                    end else
`endif
                    if (i == I_LAST) begin
                        state_next = DONE;
                        i_next     = '0;
                    end else begin
                        i_next = i + 4'd1;
                    end
                end
            end
`ifdef RC5_DECRYPT_EN
            FINAL: begin
                if (!keys_ready) begin
                    state_next = IDLE;
                    i_next     = '0;
                end else begin
                    a_next     = a - sub[0];
                    b_next     = b - sub[1];
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            i     <= '0;
            armed <= 1'b0;
`ifdef RC5_DECRYPT_EN
            dec   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            a     <= a_next;
            b     <= b_next;
            i     <= i_next;
            armed <= (state_next == IDLE);
`ifdef RC5_DECRYPT_EN
            dec   <= dec_next;
`endif
        end
    end

endmodule

// File: tb/tb_rc5_cipher.sv
// Directed self-checking bench for rc5_cipher; decrypt steps only when RC5_DECRYPT_EN is defined.
`timescale 1ns/1ps
module tb_rc5_cipher;

    logic               clk = 1'b0;
    logic               rst;
    logic [25:0][15:0]  sub;
    logic               keys_ready;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               mode_dec;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rc5_cipher dut (
        .clk        (clk),
        .rst        (rst),
        .sub        (sub),
        .keys_ready (keys_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mode_dec   (mode_dec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference rotate built from single-bit steps.
    function automatic logic [15:0] rl(input logic [15:0] x, input int n);
        logic [15:0] y;
        y = x;
        for (int k = 0; k < n % 16; k++) y = {y[14:0], y[15]};
        return y;
    endfunction

    function automatic logic [31:0] model_enc(input logic [31:0] pt);
        logic [15:0] x;
        logic [15:0] y;
        x = pt[15:0] + sub[0];
        y = pt[31:16] + sub[1];
        for (int r = 1; r <= 12; r++) begin
            x = rl(x ^ y, int'(y % 16)) + sub[2*r];
            y = rl(y ^ x, int'(x % 16)) + sub[2*r+1];
        end
        return {y, x};
    endfunction

    // RC5-16 key schedule for an all-zero 16-byte key.
    task automatic load_zero_key();
        logic [15:0] s [26];
        logic [15:0] l [8];
        logic [15:0] ka;
        logic [15:0] kb;
        int ii;
        int jj;
        ka = '0;
        kb = '0;
        ii = 0;
        jj = 0;
        s[0] = 16'hB7E1;
        for (int t = 1; t < 26; t++) s[t] = s[t-1] + 16'h9E37;
        for (int t = 0; t < 8; t++) l[t] = '0;
        for (int k = 0; k < 78; k++) begin
            ka = rl(s[ii] + ka + kb, 3);
            s[ii] = ka;
            kb = rl(l[jj] + ka + kb, int'((ka + kb) % 16));
            l[jj] = kb;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % 8;
        end
        for (int t = 0; t < 26; t++) sub[t] = s[t];
    endtask

    // Called just after a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [31:0] data, input logic dec, input string tag);
        int n;
        n = 0;
        in_data  = data;
        mode_dec = dec;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, 32'(n < 40), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        mode_dec = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Full transaction with out_ready high; also checks in_ready the cycle after handshake.
    task automatic run(input logic [31:0] data, input logic dec, input logic [31:0] exp,
                       input int exp_lat, input string tag);
        int lat;
        send(data, dec, tag);
        wait_out(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data"}, out_data, exp);
        @(negedge clk);
        check({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] exp;
        logic [31:0] ct;

        rst        = 1'b1;
        sub        = '0;
        keys_ready = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        mode_dec   = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // No accept while keys are not ready.
        in_valid = 1'b1;
        in_data  = 32'h1111_2222;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("nokeys in_ready", 32'(in_ready), 32'd0);
            check("nokeys out_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;

        // All-zero subkeys and plaintext stay zero through every round.
        keys_ready = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        run(32'h0000_0000, 1'b0, 32'h0000_0000, 13, "zero");

        // Zero-key schedule; result held while out_ready is low.
        load_zero_key();
        out_ready = 1'b0;
        exp = model_enc(32'h1234_5678);
        send(32'h1234_5678, 1'b0, "hold");
        wait_out(lat);
        check("hold latency", 32'(lat), 32'd13);
        for (int k = 0; k < 5; k++) begin
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold data", out_data, exp);
            check("hold in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold out_valid after hs", 32'(out_valid), 32'd0);
        check("hold in_ready after hs", 32'(in_ready), 32'd1);

        // keys_ready drop mid-operation aborts without a result.
        send(32'hCAFE_F00D, 1'b0, "abort");
        repeat (5) @(negedge clk);
        keys_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort no out_valid", 32'(seen), 32'd0);
        keys_ready = 1'b1;
        @(negedge clk);
        run(32'hCAFE_F00D, 1'b0, model_enc(32'hCAFE_F00D), 13, "after abort");

        // Synchronous reset mid-operation drops the block.
        send(32'h0BAD_F00D, 1'b0, "rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run(32'h0BAD_F00D, 1'b0, model_enc(32'h0BAD_F00D), 13, "after rst");

        // Back-to-back blocks: run() returns exactly at the re-accept point.
        run(32'hA5A5_0F0F, 1'b0, model_enc(32'hA5A5_0F0F), 13, "b2b first");
        run(32'h8000_0001, 1'b0, model_enc(32'h8000_0001), 13, "b2b second");

`ifdef RC5_DECRYPT_EN
        ct = model_enc(32'hDEAD_BEEF);
        run(32'hDEAD_BEEF, 1'b0, ct, 13, "enc deadbeef");
        run(ct, 1'b1, 32'hDEAD_BEEF, 14, "dec deadbeef");
`else
        // Without the decrypt build mode_dec is ignored.
        ct = model_enc(32'hDEAD_BEEF);
        run(32'hDEAD_BEEF, 1'b1, ct, 13, "mode_dec ignored");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
